// File: rtl/axi_rd_arbiter_if.sv
// Bundle of the cache-side request/refill ports and the shared AXI read channels.
// The arbiter connects through the master modport; the caches and interconnect use slave.
interface axi_rd_arbiter_if #(
    parameter int unsigned DATA_W = 32
) ();
    // Icache side
    logic              i_arvalid;
    logic [31:0]       i_araddr;
    logic              i_arready;
    logic              i_rvalid;
    logic              i_rready;
    logic              i_rlast;
    logic [DATA_W-1:0] i_rdata;
    // Dcache side
    logic              d_arvalid;
    logic [31:0]       d_araddr;
    logic              d_arready;
    logic              d_rvalid;
    logic              d_rready;
    logic              d_rlast;
    logic [DATA_W-1:0] d_rdata;
    // Shared AXI AR / R channels
    logic              m_arvalid;
    logic              m_arready;
    logic [31:0]       m_araddr;
    logic [3:0]        m_arid;
    logic [7:0]        m_arlen;
    logic [2:0]        m_arsize;
    logic [1:0]        m_arburst;
    logic              m_rvalid;
    logic              m_rready;
    logic [DATA_W-1:0] m_rdata;
    logic              m_rlast;
    logic [1:0]        m_rresp;
    logic [3:0]        m_rid;

    modport master (
        input  i_arvalid, i_araddr, i_rready,
        input  d_arvalid, d_araddr, d_rready,
        input  m_arready, m_rvalid, m_rdata, m_rlast, m_rresp, m_rid,
        output i_arready, i_rvalid, i_rlast, i_rdata,
        output d_arready, d_rvalid, d_rlast, d_rdata,
        output m_arvalid, m_araddr, m_arid, m_arlen, m_arsize, m_arburst, m_rready
    );

    modport slave (
        output i_arvalid, i_araddr, i_rready,
        output d_arvalid, d_araddr, d_rready,
        output m_arready, m_rvalid, m_rdata, m_rlast, m_rresp, m_rid,
        input  i_arready, i_rvalid, i_rlast, i_rdata,
        input  d_arready, d_rvalid, d_rlast, d_rdata,
        input  m_arvalid, m_araddr, m_arid, m_arlen, m_arsize, m_arburst, m_rready
    );
endinterface

// File: rtl/axi_rd_arbiter.sv
// Round-robin arbiter that merges icache and dcache line refills onto one AXI read port.
// One burst outstanding at a time; returned beats are passed through unbuffered.
module axi_rd_arbiter #(
    parameter int unsigned BURST_LEN = 4,
    parameter int unsigned DATA_W    = 32
) (
    input  logic              clk,
    input  logic              rstn,
    axi_rd_arbiter_if.master  bus,
    output logic              bus_err
);

    typedef enum logic [1:0] {StIdle, StAddr, StData} state_e;

    state_e      state_q, state_d;
    // One-hot grant: bit 0 = icache, bit 1 = dcache, 00 = none
    logic [1:0]  grant_q, grant_d;
    // Only updated on a tie; reset to dcache so icache wins the first tie
    logic        last_dcache_q, last_dcache_d;
    logic [7:0]  beat_q, beat_d;
    logic [31:0] araddr_q, araddr_d;

    logic        pick_d;
    logic        beat;
    logic [3:0]  grant_id;

    assign bus.m_arlen   = 8'(BURST_LEN - 1);
    assign bus.m_arsize  = 3'($clog2(DATA_W / 8));
    assign bus.m_arburst = 2'b01;

    assign pick_d   = bus.d_arvalid & (~bus.i_arvalid | ~last_dcache_q);
    assign grant_id = {3'b000, grant_q[1]};
    assign beat     = bus.m_rvalid & bus.m_rready;

    // Next-state, grant bookkeeping and all handshake outputs
    always_comb begin
        state_d       = state_q;
        grant_d       = grant_q;
        last_dcache_d = last_dcache_q;
        beat_d        = beat_q;
        araddr_d      = araddr_q;

        bus.i_arready = 1'b0;
        bus.d_arready = 1'b0;
        bus.i_rvalid  = 1'b0;
        bus.d_rvalid  = 1'b0;
        bus.i_rlast   = 1'b0;
        bus.d_rlast   = 1'b0;
        bus.i_rdata   = '0;
        bus.d_rdata   = '0;
        bus.m_arvalid = 1'b0;
        bus.m_araddr  = '0;
        bus.m_arid    = '0;
        bus.m_rready  = 1'b0;
        bus_err       = 1'b0;

        unique case (state_q)
            StIdle: begin
                // rstn gate keeps arready low while reset is held
                if (rstn && (bus.i_arvalid || bus.d_arvalid)) begin
                    araddr_d      = pick_d ? bus.d_araddr : bus.i_araddr;
                    grant_d       = pick_d ? 2'b10 : 2'b01;
                    bus.i_arready = ~pick_d;
                    bus.d_arready = pick_d;
                    if (bus.i_arvalid && bus.d_arvalid) begin
                        last_dcache_d = pick_d;
                    end
                    state_d = StAddr;
                end
            end
            StAddr: begin
                bus.m_arvalid = 1'b1;
                bus.m_araddr  = araddr_q;
                bus.m_arid    = grant_id;
                if (bus.m_arready) begin
                    beat_d  = '0;
                    state_d = StData;
                end
            end
            StData: begin
                bus.m_rready = (grant_q[0] & bus.i_rready) | (grant_q[1] & bus.d_rready);
                bus.i_rvalid = bus.m_rvalid & grant_q[0];
                bus.d_rvalid = bus.m_rvalid & grant_q[1];
                bus.i_rdata  = bus.m_rdata;
                bus.d_rdata  = bus.m_rdata;
                bus.i_rlast  = bus.m_rlast;
                bus.d_rlast  = bus.m_rlast;
                if (beat) begin
                    beat_d  = beat_q + 8'd1;
                    // Errors are flagged but the burst still runs to m_rlast
                    bus_err = (bus.m_rlast && (beat_q != 8'(BURST_LEN - 1))) ||
                              (bus.m_rid != grant_id) ||
                              (bus.m_rresp != 2'b00);
                    if (bus.m_rlast) begin
                        grant_d = 2'b00;
                        state_d = StIdle;
                    end
                end
            end
            default: begin
                grant_d = 2'b00;
                state_d = StIdle;
            end
        endcase
    end

    // State and bookkeeping registers with asynchronous reset
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q       <= StIdle;
            grant_q       <= 2'b00;
            last_dcache_q <= 1'b1;
            beat_q        <= '0;
            araddr_q      <= '0;
        end else begin
            state_q       <= state_d;
            grant_q       <= grant_d;
            last_dcache_q <= last_dcache_d;
            beat_q        <= beat_d;
            araddr_q      <= araddr_d;
        end
    end

endmodule

// File: tb/tb_axi_rd_arbiter.sv
// Directed self-checking bench for axi_rd_arbiter.
// Inputs change on the falling edge; outputs are sampled 1ns later.
module tb_axi_rd_arbiter;

    logic clk;
    logic rstn;
    logic bus_err;
    int   n_cmp;
    int   n_err;

    axi_rd_arbiter_if #(.DATA_W(32)) bus ();

    axi_rd_arbiter #(.BURST_LEN(4), .DATA_W(32)) dut (
        .clk     (clk),
        .rstn    (rstn),
        .bus     (bus),
        .bus_err (bus_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog act=timeout exp=finish");
        $fatal(1);
    end

    task automatic clear_inputs();
        bus.i_arvalid = 0; bus.i_araddr = 0; bus.i_rready = 0;
        bus.d_arvalid = 0; bus.d_araddr = 0; bus.d_rready = 0;
        bus.m_arready = 0; bus.m_rvalid = 0; bus.m_rdata  = 0;
        bus.m_rlast   = 0; bus.m_rresp  = 0; bus.m_rid    = 0;
    endtask

    task automatic do_reset();
        rstn = 1'b0;
        clear_inputs();
        repeat (2) @(negedge clk);
        rstn = 1'b1;
    endtask

    // Accept the pending AR (called in ADDR); returns at the first DATA cycle
    task automatic ar_accept();
        bus.m_arready = 1'b1;
        @(negedge clk);
        bus.m_arready = 1'b0;
    endtask

    // Clean burst of n beats; returns at the first cycle after the last beat
    task automatic send_beats(input logic [3:0] id, input int n);
        bus.i_rready = 1'b1;
        bus.d_rready = 1'b1;
        for (int k = 0; k < n; k++) begin
            bus.m_rvalid = 1'b1;
            bus.m_rid    = id;
            bus.m_rresp  = 2'b00;
            bus.m_rdata  = 32'hB0 + 32'(k);
            bus.m_rlast  = (k == n - 1);
            @(negedge clk);
        end
        bus.m_rvalid = 1'b0;
        bus.m_rlast  = 1'b0;
        bus.m_rid    = 4'd0;
    endtask

    task automatic test_reset();
        rstn = 1'b0;
        clear_inputs();
        bus.i_arvalid = 1; bus.d_arvalid = 1; bus.m_rvalid = 1; bus.m_rlast = 1;
        bus.m_rresp = 2; bus.m_rdata = 32'hDEADBEEF; bus.i_rready = 1; bus.d_rready = 1;
        repeat (2) @(negedge clk);
        #1;
        n_cmp++; if (bus.i_arready !== 1'b0) begin n_err++; $display("FAIL rst_i_arready act=%0h exp=0", bus.i_arready); end
        n_cmp++; if (bus.d_arready !== 1'b0) begin n_err++; $display("FAIL rst_d_arready act=%0h exp=0", bus.d_arready); end
        n_cmp++; if (bus.m_arvalid !== 1'b0) begin n_err++; $display("FAIL rst_m_arvalid act=%0h exp=0", bus.m_arvalid); end
        n_cmp++; if (bus.m_araddr !== 32'h0) begin n_err++; $display("FAIL rst_m_araddr act=%0h exp=0", bus.m_araddr); end
        n_cmp++; if (bus.m_rready !== 1'b0) begin n_err++; $display("FAIL rst_m_rready act=%0h exp=0", bus.m_rready); end
        n_cmp++; if (bus.i_rvalid !== 1'b0 || bus.d_rvalid !== 1'b0) begin n_err++; $display("FAIL rst_rvalid act=%0h%0h exp=00", bus.i_rvalid, bus.d_rvalid); end
        n_cmp++; if (bus.i_rdata !== 32'h0) begin n_err++; $display("FAIL rst_i_rdata act=%0h exp=0", bus.i_rdata); end
        n_cmp++; if (bus_err !== 1'b0) begin n_err++; $display("FAIL rst_bus_err act=%0h exp=0", bus_err); end
        n_cmp++; if (bus.m_arlen !== 8'd3) begin n_err++; $display("FAIL rst_m_arlen act=%0h exp=3", bus.m_arlen); end
        n_cmp++; if (bus.m_arsize !== 3'd2) begin n_err++; $display("FAIL rst_m_arsize act=%0h exp=2", bus.m_arsize); end
        n_cmp++; if (bus.m_arburst !== 2'b01) begin n_err++; $display("FAIL rst_m_arburst act=%0h exp=1", bus.m_arburst); end
        @(negedge clk);
        clear_inputs();
        rstn = 1'b1;
    endtask

    task automatic test_icache_alone();
        do_reset();
        bus.i_arvalid = 1; bus.i_araddr = 32'h1C000010;
        #1;
        n_cmp++; if (bus.i_arready !== 1'b1) begin n_err++; $display("FAIL ic_arready act=%0h exp=1", bus.i_arready); end
        n_cmp++; if (bus.m_arvalid !== 1'b0) begin n_err++; $display("FAIL ic_arvalid_early act=%0h exp=0", bus.m_arvalid); end
        @(negedge clk);
        bus.i_arvalid = 0;
        // m_arready held low for two ADDR cycles
        for (int w = 0; w < 2; w++) begin
            #1;
            n_cmp++; if (bus.i_arready !== 1'b0) begin n_err++; $display("FAIL ic_arready_pulse act=%0h exp=0", bus.i_arready); end
            n_cmp++; if (bus.m_arvalid !== 1'b1) begin n_err++; $display("FAIL ic_arvalid act=%0h exp=1", bus.m_arvalid); end
            n_cmp++; if (bus.m_araddr !== 32'h1C000010) begin n_err++; $display("FAIL ic_araddr act=%0h exp=1c000010", bus.m_araddr); end
            n_cmp++; if (bus.m_arid !== 4'd0) begin n_err++; $display("FAIL ic_arid act=%0h exp=0", bus.m_arid); end
            @(negedge clk);
        end
        ar_accept();
        #1;
        n_cmp++; if (bus.m_arvalid !== 1'b0) begin n_err++; $display("FAIL ic_arvalid_drop act=%0h exp=0", bus.m_arvalid); end
        bus.i_rready = 1;
        for (int k = 0; k < 4; k++) begin
            bus.m_rvalid = 1; bus.m_rid = 0; bus.m_rresp = 0;
            bus.m_rdata = 32'hA0 + 32'(k); bus.m_rlast = (k == 3);
            #1;
            n_cmp++; if (bus.i_rvalid !== 1'b1) begin n_err++; $display("FAIL ic_rvalid beat%0d act=%0h exp=1", k, bus.i_rvalid); end
            n_cmp++; if (bus.i_rdata !== 32'hA0 + 32'(k)) begin n_err++; $display("FAIL ic_rdata beat%0d act=%0h exp=%0h", k, bus.i_rdata, 32'hA0 + k); end
            n_cmp++; if (bus.i_rlast !== (k == 3)) begin n_err++; $display("FAIL ic_rlast beat%0d act=%0h exp=%0h", k, bus.i_rlast, (k == 3)); end
            n_cmp++; if (bus.d_rvalid !== 1'b0) begin n_err++; $display("FAIL ic_d_rvalid beat%0d act=%0h exp=0", k, bus.d_rvalid); end
            n_cmp++; if (bus.m_rready !== 1'b1) begin n_err++; $display("FAIL ic_m_rready beat%0d act=%0h exp=1", k, bus.m_rready); end
            n_cmp++; if (bus_err !== 1'b0) begin n_err++; $display("FAIL ic_bus_err beat%0d act=%0h exp=0", k, bus_err); end
            @(negedge clk);
        end
        bus.m_rvalid = 0; bus.m_rlast = 0;
        #1;
        n_cmp++; if (bus.m_rready !== 1'b0) begin n_err++; $display("FAIL ic_idle_rready act=%0h exp=0", bus.m_rready); end
    endtask

    task automatic test_round_robin();
        do_reset();
        bus.i_arvalid = 1; bus.i_araddr = 32'h100;
        bus.d_arvalid = 1; bus.d_araddr = 32'h200;
        #1;
        n_cmp++; if (bus.i_arready !== 1'b1 || bus.d_arready !== 1'b0) begin n_err++; $display("FAIL rr_tie1 act=%0h%0h exp=10", bus.i_arready, bus.d_arready); end
        @(negedge clk);
        bus.i_arvalid = 0;
        #1;
        n_cmp++; if (bus.m_arid !== 4'd0 || bus.m_araddr !== 32'h100) begin n_err++; $display("FAIL rr_first act=%0h/%0h exp=0/100", bus.m_arid, bus.m_araddr); end
        n_cmp++; if (bus.d_arready !== 1'b0) begin n_err++; $display("FAIL rr_d_wait act=%0h exp=0", bus.d_arready); end
        ar_accept();
        send_beats(4'd0, 4);
        #1;
        n_cmp++; if (bus.d_arready !== 1'b1) begin n_err++; $display("FAIL rr_d_grant act=%0h exp=1", bus.d_arready); end
        @(negedge clk);
        bus.d_arvalid = 0;
        #1;
        n_cmp++; if (bus.m_arid !== 4'd1 || bus.m_araddr !== 32'h200) begin n_err++; $display("FAIL rr_second act=%0h/%0h exp=1/200", bus.m_arid, bus.m_araddr); end
        ar_accept();
        send_beats(4'd1, 4);
        // Second tie: icache won the last tie, so dcache goes first
        bus.i_arvalid = 1; bus.i_araddr = 32'h300;
        bus.d_arvalid = 1; bus.d_araddr = 32'h400;
        #1;
        n_cmp++; if (bus.i_arready !== 1'b0 || bus.d_arready !== 1'b1) begin n_err++; $display("FAIL rr_tie2 act=%0h%0h exp=01", bus.i_arready, bus.d_arready); end
        @(negedge clk);
        bus.d_arvalid = 0;
        #1;
        n_cmp++; if (bus.m_arid !== 4'd1 || bus.m_araddr !== 32'h400) begin n_err++; $display("FAIL rr_third act=%0h/%0h exp=1/400", bus.m_arid, bus.m_araddr); end
        ar_accept();
        send_beats(4'd1, 4);
        #1;
        n_cmp++; if (bus.i_arready !== 1'b1) begin n_err++; $display("FAIL rr_i_after act=%0h exp=1", bus.i_arready); end
        @(negedge clk);
        bus.i_arvalid = 0;
        ar_accept();
        send_beats(4'd0, 4);
    endtask

    task automatic test_backpressure();
        int seen;
        int idx;
        do_reset();
        bus.i_arvalid = 1; bus.i_araddr = 32'h40;
        @(negedge clk);
        bus.i_arvalid = 0;
        ar_accept();
        seen = 0;
        idx  = 0;
        for (int c = 0; c < 7; c++) begin
            bus.i_rready = (c < 2 || c > 4);
            bus.m_rvalid = 1; bus.m_rid = 0; bus.m_rresp = 0;
            bus.m_rdata  = 32'hC0 + 32'(idx);
            bus.m_rlast  = (idx == 3);
            #1;
            n_cmp++; if (bus.m_rready !== bus.i_rready) begin n_err++; $display("FAIL bp_rready c%0d act=%0h exp=%0h", c, bus.m_rready, bus.i_rready); end
            n_cmp++; if (bus.i_rdata !== 32'hC0 + 32'(idx)) begin n_err++; $display("FAIL bp_rdata c%0d act=%0h exp=%0h", c, bus.i_rdata, 32'hC0 + idx); end
            if (bus.i_rvalid && bus.i_rready) seen++;
            if (bus.i_rready) idx++;
            @(negedge clk);
        end
        bus.m_rvalid = 0; bus.m_rlast = 0;
        #1;
        n_cmp++; if (seen !== 4) begin n_err++; $display("FAIL bp_beats act=%0d exp=4", seen); end
        n_cmp++; if (dut.beat_q !== 8'd4) begin n_err++; $display("FAIL bp_beat_cnt act=%0d exp=4", dut.beat_q); end
        n_cmp++; if (bus.m_rready !== 1'b0) begin n_err++; $display("FAIL bp_idle act=%0h exp=0", bus.m_rready); end
    endtask

    task automatic test_errors();
        do_reset();
        bus.d_arvalid = 1; bus.d_araddr = 32'h80;
        @(negedge clk);
        bus.d_arvalid = 0;
        ar_accept();
        bus.d_rready = 1; bus.i_rready = 1;
        bus.m_rvalid = 1; bus.m_rid = 1; bus.m_rdata = 32'h1; bus.m_rlast = 0;
        #1;
        n_cmp++; if (bus_err !== 1'b0) begin n_err++; $display("FAIL err_clean act=%0h exp=0", bus_err); end
        @(negedge clk);
        // Early m_rlast on the second beat
        bus.m_rdata = 32'h2; bus.m_rlast = 1;
        #1;
        n_cmp++; if (bus_err !== 1'b1) begin n_err++; $display("FAIL err_early_last act=%0h exp=1", bus_err); end
        n_cmp++; if (bus.d_rlast !== 1'b1) begin n_err++; $display("FAIL err_d_rlast act=%0h exp=1", bus.d_rlast); end
        @(negedge clk);
        bus.m_rvalid = 0; bus.m_rlast = 0; bus.m_rid = 0;
        #1;
        n_cmp++; if (bus_err !== 1'b0) begin n_err++; $display("FAIL err_one_pulse act=%0h exp=0", bus_err); end
        n_cmp++; if (bus.m_rready !== 1'b0) begin n_err++; $display("FAIL err_idle act=%0h exp=0", bus.m_rready); end
        bus.i_arvalid = 1; bus.i_araddr = 32'h90;
        #1;
        n_cmp++; if (bus.i_arready !== 1'b1) begin n_err++; $display("FAIL err_regrant act=%0h exp=1", bus.i_arready); end
        @(negedge clk);
        bus.i_arvalid = 0;
        ar_accept();
        // Beats: SLVERR, clean, wrong id, clean last
        for (int k = 0; k < 4; k++) begin
            bus.m_rvalid = 1;
            bus.m_rresp  = (k == 0) ? 2'd2 : 2'd0;
            bus.m_rid    = (k == 2) ? 4'd1 : 4'd0;
            bus.m_rlast  = (k == 3);
            #1;
            n_cmp++; if (bus_err !== (k == 0 || k == 2)) begin n_err++; $display("FAIL err_resp_id beat%0d act=%0h exp=%0h", k, bus_err, (k == 0 || k == 2)); end
            @(negedge clk);
        end
        bus.m_rvalid = 0; bus.m_rlast = 0; bus.m_rresp = 0; bus.m_rid = 0;
    endtask

    task automatic test_contention();
        do_reset();
        bus.d_arvalid = 1; bus.d_araddr = 32'h300;
        @(negedge clk);
        bus.d_arvalid = 0;
        bus.i_arvalid = 1; bus.i_araddr = 32'h500;
        #1;
        n_cmp++; if (bus.i_arready !== 1'b0) begin n_err++; $display("FAIL ct_addr_arready act=%0h exp=0", bus.i_arready); end
        ar_accept();
        bus.d_rready = 1; bus.i_rready = 1;
        for (int k = 0; k < 4; k++) begin
            bus.m_rvalid = 1; bus.m_rid = 1; bus.m_rdata = 32'hD0 + 32'(k); bus.m_rlast = (k == 3);
            #1;
            n_cmp++; if (bus.i_rvalid !== 1'b0 || bus.i_arready !== 1'b0) begin n_err++; $display("FAIL ct_icache_quiet beat%0d act=%0h%0h exp=00", k, bus.i_rvalid, bus.i_arready); end
            n_cmp++; if (bus.d_rvalid !== 1'b1) begin n_err++; $display("FAIL ct_d_rvalid beat%0d act=%0h exp=1", k, bus.d_rvalid); end
            @(negedge clk);
        end
        bus.m_rvalid = 0; bus.m_rlast = 0; bus.m_rid = 0;
        #1;
        n_cmp++; if (bus.i_arready !== 1'b1) begin n_err++; $display("FAIL ct_i_grant act=%0h exp=1", bus.i_arready); end
        @(negedge clk);
        bus.i_arvalid = 0;
        #1;
        n_cmp++; if (bus.m_arvalid !== 1'b1 || bus.m_arid !== 4'd0 || bus.m_araddr !== 32'h500) begin n_err++; $display("FAIL ct_i_issue act=%0h/%0h/%0h exp=1/0/500", bus.m_arvalid, bus.m_arid, bus.m_araddr); end
        ar_accept();
        send_beats(4'd0, 4);
    endtask

    task automatic test_async_reset();
        do_reset();
        bus.i_arvalid = 1; bus.i_araddr = 32'h600;
        @(negedge clk);
        bus.i_arvalid = 0;
        #1;
        n_cmp++; if (bus.m_arvalid !== 1'b1) begin n_err++; $display("FAIL ar_pre act=%0h exp=1", bus.m_arvalid); end
        #1;
        rstn = 1'b0;
        #1;
        n_cmp++; if (bus.m_arvalid !== 1'b0 || bus.m_araddr !== 32'h0) begin n_err++; $display("FAIL ar_drop act=%0h/%0h exp=0/0", bus.m_arvalid, bus.m_araddr); end
        @(negedge clk);
        rstn = 1'b1;
        bus.i_arvalid = 1; bus.i_araddr = 32'h700;
        #1;
        n_cmp++; if (bus.i_arready !== 1'b1) begin n_err++; $display("FAIL ar_idle act=%0h exp=1", bus.i_arready); end
        @(negedge clk);
        bus.i_arvalid = 0;
        #1;
        n_cmp++; if (bus.m_arvalid !== 1'b1 || bus.m_araddr !== 32'h700) begin n_err++; $display("FAIL ar_new act=%0h/%0h exp=1/700", bus.m_arvalid, bus.m_araddr); end
        ar_accept();
        bus.i_rready = 1; bus.m_rvalid = 1; bus.m_rdata = 32'hE0; bus.m_rid = 0;
        #1;
        n_cmp++; if (bus.i_rvalid !== 1'b1 || bus.i_rdata !== 32'hE0) begin n_err++; $display("FAIL ar_beat act=%0h/%0h exp=1/e0", bus.i_rvalid, bus.i_rdata); end
        @(negedge clk);
        send_beats(4'd0, 3);
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        rstn  = 1'b0;
        clear_inputs();
        @(negedge clk);
        test_reset();
        test_icache_alone();
        test_round_robin();
        test_backpressure();
        test_errors();
        test_contention();
        test_async_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
